// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronizer, mid-bit sampling FSM and receive buffer.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FWFT FIFO; otherwise a single holding register.
module uart_rx_core #(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [15:0] baud_div_i,
    input  logic        rx_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        frame_err_o,
    output logic        overrun_o,
    output logic        busy_o
);

    if (SYNC_STAGES < 2) begin : g_sync_chk
        $error("uart_rx_core: SYNC_STAGES must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("uart_rx_core: FIFO_DEPTH must be a power of 2 and at least 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rxs;
    logic [15:0]            div_q;
    logic [15:0]            cnt_q;
    logic [2:0]             bit_q;
    logic [7:0]             shift_q;
    logic                   frame_err_q;
    logic                   busy_q;
    logic                   overrun_q;
    logic                   cnt_end;
    logic                   cnt_half;
    logic                   push;
    logic                   ferr;
    logic                   pop;

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign cnt_end  = (cnt_q == div_q - 16'd1);
    assign cnt_half = (cnt_q == (div_q >> 1) - 16'd1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
            prev_q <= rxs;
        end
    end

    // Stop-bit verdict is taken combinationally so the byte lands in the buffer on the sampling edge.
    always_comb begin
        push = 1'b0;
        ferr = 1'b0;
        if (en_i && state_q == STOP && cnt_end) begin
            push = rxs;
            ferr = ~rxs;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            div_q       <= 16'd0;
            cnt_q       <= 16'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= ferr;
            if (state_q != IDLE && !en_i) begin
                state_q <= IDLE;
                cnt_q   <= 16'd0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // prev_q low after a break keeps a held-low line from retriggering.
                        if (en_i && prev_q && !rxs) begin
                            div_q   <= (baud_div_i < 16'd4) ? 16'd4 : baud_div_i;
                            cnt_q   <= 16'd0;
                            state_q <= START;
                            busy_q  <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt_half) begin
                            cnt_q <= 16'd0;
                            bit_q <= 3'd0;
                            if (rxs) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= DATA;
                            end
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    DATA: begin
                        if (cnt_end) begin
                            cnt_q   <= 16'd0;
                            shift_q <= {rxs, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                state_q <= STOP;
                            end
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    STOP: begin
                        if (cnt_end) begin
                            cnt_q   <= 16'd0;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 16'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef UART_RX_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [PW:0]   count_q;
    logic          full;
    logic          wr;

    assign full = (count_q == (PW + 1)'(FIFO_DEPTH));
    assign pop  = (count_q != '0) && rx_ready_i;
    assign wr   = push && (!full || pop);

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_q[wptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push && full && !pop;
            if (wr) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            case ({wr, pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rx_valid_o = (count_q != '0);
    assign rx_data_o  = (count_q != '0) ? mem_q[rptr_q] : 8'h00;
`else
    logic [7:0] hold_q;
    logic       valid_q;

    assign pop = valid_q && rx_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_q    <= 8'h00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (push && (!valid_q || pop)) begin
                hold_q  <= shift_q;
                valid_q <= 1'b1;
            end else begin
                if (push) begin
                    overrun_q <= 1'b1;
                end
                if (pop) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign rx_valid_o = valid_q;
    assign rx_data_o  = hold_q;
`endif

    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames, expected bytes queued, monitor pops on handshake.
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] div;
    logic        rx;
    logic        ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    uart_rx_core dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .baud_div_i  (div),
        .rx_i        (rx),
        .rx_data_o   (rx_data),
        .rx_valid_o  (rx_valid),
        .rx_ready_i  (ready),
        .frame_err_o (frame_err),
        .overrun_o   (overrun),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    int err_seen = 0;
    int ovr_seen = 0;
    int vld_cyc  = 0;
    int first_vld_cyc = -1;
    int exp_ovr  = 0;
    int start_cyc;
    int v0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(int'(div));
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(int'(div));
        end
        rx = stop_bit;
        tick(int'(div));
        rx = 1'b1;
    endtask

    // Monitor: pulse counters and scoreboard pops on every accepted byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) err_seen++;
            if (overrun) ovr_seen++;
            if (rx_valid) begin
                vld_cyc++;
                if (first_vld_cyc < 0) first_vld_cyc = cyc;
            end
            if (rx_valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_data);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        div   = 16'd16;
        rx    = 1'b1;
        ready = 1'b1;
        tick(3);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick(5);

        // 0xB3 at div 128: one-cycle valid about 9.5*128+2 cycles after the start edge
        div = 16'd128;
        vld_cyc = 0;
        first_vld_cyc = -1;
        exp_q.push_back(8'hB3);
        start_cyc = cyc;
        send_frame(8'hB3, 1'b1);
        tick(20);
        check_range("b3_latency", first_vld_cyc - start_cyc, 1214, 1224);
        check("b3_valid_cycles", vld_cyc, 1);
        check("b3_ferr", err_seen, 0);
        check("b3_ovr", ovr_seen, 0);
        check("b3_busy_after", {31'd0, busy}, 32'd0);
        check("b3_consumed", exp_q.size(), 0);

        // 0x55 with a low stop bit
        div = 16'd16;
        send_frame(8'h55, 1'b0);
        tick(20);
        check("55_ferr_once", err_seen, 1);
        check("55_no_valid", vld_cyc, 1);

        // 40-cycle glitch at div 128
        div = 16'd128;
        rx = 1'b0;
        tick(20);
        check("glitch_busy_mid", {31'd0, busy}, 32'd1);
        tick(20);
        rx = 1'b1;
        tick(32);
        check("glitch_busy_end", {31'd0, busy}, 32'd0);
        tick(200);
        check("glitch_no_valid", vld_cyc, 1);
        check("glitch_no_ferr", err_seen, 1);

        // Three back-to-back bytes with consumer stalled
        div = 16'd16;
        ready = 1'b0;
`ifdef UART_RX_FIFO_EN
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        exp_ovr = 0;
`else
        exp_q.push_back(8'h01);
        exp_ovr = 2;
`endif
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        tick(20);
        check("stall_valid", {31'd0, rx_valid}, 32'd1);
        check("stall_head", {24'd0, rx_data}, 32'h01);
        check("stall_ovr", ovr_seen, exp_ovr);
        ready = 1'b1;
        tick(10);
        check("stall_drained", exp_q.size(), 0);
        check("stall_valid_low", {31'd0, rx_valid}, 32'd0);

        // Reset during DATA of 0xA5, then a clean 0xA5
        rx = 1'b0;
        tick(16);
        rx = 1'b1;
        tick(16);
        rx = 1'b0;
        tick(8);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        rx = 1'b1;
        tick(1);
        check("midrst_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_data", {24'd0, rx_data}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ferr", {31'd0, frame_err}, 32'd0);
        check("midrst_ovr", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        v0 = vld_cyc;
        tick(200);
        check("midrst_no_partial", vld_cyc, v0);
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        tick(20);
        check("a5_consumed", exp_q.size(), 0);

        // en_i dropped for one cycle during bit 4 of 0x3C, then a clean 0x3C
        rx = 1'b0;
        tick(16);
        rx = 1'b0;
        tick(16);
        rx = 1'b0;
        tick(16);
        rx = 1'b1;
        tick(16);
        rx = 1'b1;
        tick(16);
        rx = 1'b1;
        tick(8);
        check("en_busy_before", {31'd0, busy}, 32'd1);
        en = 1'b0;
        tick(1);
        en = 1'b1;
        tick(1);
        check("en_busy_after", {31'd0, busy}, 32'd0);
        v0 = vld_cyc;
        tick(200);
        check("en_no_output", vld_cyc, v0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        tick(20);
        check("3c_consumed", exp_q.size(), 0);
        check("final_ferr", err_seen, 1);
        check("final_ovr", ovr_seen, exp_ovr);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
